clock_counter_core: RTL and testbench
=====================================

Name: clock_counter_core

Overview:
- Upstream producer for the on-screen text renderer in the Button_Counter_Display design.
- Generates the HH:MM:SS time-of-day value from the system clock.
- Debounces two raw push-buttons and maintains a 0..COUNT_MAX press counter.
- Outputs drive the renderer's hour/min/sec/count inputs directly; all are registered and in the `clk` domain.

Parameters:
- CLK_FREQ, 25000000, clk cycles per second; the prescaler period.
- DEBOUNCE_CYCLES, 250000, consecutive stable synchronized samples required to accept a button level change; must be ≥ 2.
- COUNT_MAX, 99, highest count value; wraps to 0 after it. Must be ≤ 99 for 2-digit display.
- BTN_ACTIVE_LOW, 0, 1 = raw buttons read 0 when pressed (inverted before synchronizer).

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  synchronous, active-high reset
- btn_inc  in  1  raw asynchronous increment button
- btn_clr  in  1  raw asynchronous clear button
- hour  out  5  hours 0..23
- min  out  6  minutes 0..59
- sec  out  6  seconds 0..59
- count  out  8  press counter 0..COUNT_MAX
- sec_tick  out  1  one-cycle pulse, asserted on the edge sec updates
- inc_pulse  out  1  one-cycle pulse per accepted increment press

Behaviour:
- One clock `clk`; reset is synchronous and active-high on `rst`; no other resets or clock domains.
- Reset (`rst` high at an edge) sets:
  - hour, min, sec, count, sec_tick, inc_pulse to 0.
  - Prescaler to 0.
  - Synchronizer FFs, debounce counters and debounced (stable) states to the not-pressed level.
- Reset mid-operation discards any partially debounced press and any partial second.
- Prescaler:
  - Counts 0..CLK_FREQ-1. On the edge where it holds CLK_FREQ-1, it loads 0, sec_tick is registered 1 and time advances on that same edge.
  - sec_tick is 0 on all other edges, giving exactly one tick per CLK_FREQ cycles.
- Time advance on tick:
  - sec=59 → sec 0 and min increments; min=59 with that carry → min 0 and hour increments; hour=23 with that carry → hour 0.
  - 23:59:59 → 00:00:00 on a single edge.
  - No intermediate illegal values (e.g. sec=60) are ever visible.
- Button path, per button:
  - Optional inversion per BTN_ACTIVE_LOW.
  - 2-FF synchronizer, then debounce counter.
  - If the synchronized level equals the stable state, the counter is held at 0.
  - If it differs, the counter increments. When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable state flips and the counter clears.
  - Any equal sample before that point clears the counter, so glitches shorter than DEBOUNCE_CYCLES cycles are rejected.
- Press detect:
  - Stable 0→1 transition registers a one-cycle press pulse on the following edge.
  - Release (1→0) produces nothing. Holding the button produces exactly one pulse.
  - Latency: raw level first sampled at edge E and held → pulse high after edge E+DEBOUNCE_CYCLES+2.
- Count update (same edge as the press pulse):
  - clr press → count 0.
  - Else inc press → count = (count==COUNT_MAX) ? 0 : count+1.
  - Simultaneous clr and inc press → clr wins; inc_pulse still asserts.
  - inc_pulse mirrors the increment-button press pulse.
- Time and count logic are independent: a tick and a press on the same edge both take effect.
- Arithmetic is unsigned; the prescaler is sized to clog2(CLK_FREQ); the debounce counter is sized to clog2(DEBOUNCE_CYCLES).

Test Plan (CLK_FREQ=10, DEBOUNCE_CYCLES=4 unless noted):
- rst high 3 cycles, then low → all outputs 0; first sec_tick exactly 10 cycles after reset release; sec=1 on that edge; ticks every 10 cycles thereafter.
- Preload time to 23:59:58 via reset+ticks (or force), run 2 ticks → 23:59:59, then 00:00:00 on one edge; sec_tick high 1 cycle each.
- btn_inc raised and held 40 cycles → exactly one inc_pulse, at edge E+6; count 0→1; release → no pulse, count stays 1.
- btn_inc glitches high for 3 cycles, low 5, high 2 → no inc_pulse, count unchanged.
- 100 clean presses from count 0 → count reaches 99 after press 99, wraps to 0 on press 100.
- count=57; btn_inc and btn_clr pressed on the same edge → count 0 and inc_pulse high; assert rst during a partially debounced press → no pulse after release of rst.

Source files
------------

// File: rtl/clock_counter_core.sv
// ============================================================================
// clock_counter_core: HH:MM:SS time-of-day plus debounced two-button press counter
// Rev 1.0
// ============================================================================
`default_nettype none

module clock_counter_core #(
    parameter int CLK_FREQ        = 25000000,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int COUNT_MAX       = 99,
    parameter int BTN_ACTIVE_LOW  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_inc,
    input  logic       btn_clr,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [7:0] count,
    output logic       sec_tick,
    output logic       inc_pulse
);

    localparam int                c_PRESC_W    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int                c_DB_W       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(CLK_FREQ - 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST    = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]        c_CNT_MAX    = 8'(COUNT_MAX);

    logic [c_PRESC_W-1:0] r_presc;
    logic [4:0]           r_hour;
    logic [5:0]           r_min;
    logic [5:0]           r_sec;
    logic [7:0]           r_count;
    logic                 r_sec_tick;
    logic                 r_inc_pulse;

    // Index 0 = increment button, index 1 = clear button; 1 always means pressed.
    logic [1:0] w_raw;
    logic [1:0] w_press;

    assign w_raw = (BTN_ACTIVE_LOW != 0) ? ~{btn_clr, btn_inc} : {btn_clr, btn_inc};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic [1:0]        r_sync;
        logic [c_DB_W-1:0] r_db_cnt;
        logic              r_stable;
        logic              r_stable_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync     <= 2'b00;
                r_db_cnt   <= '0;
                r_stable   <= 1'b0;
                r_stable_q <= 1'b0;
            end else begin
                r_sync     <= {r_sync[0], w_raw[gi]};
                r_stable_q <= r_stable;
                if (r_sync[1] == r_stable) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == c_DB_LAST) begin
                    r_stable <= ~r_stable;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end

        assign w_press[gi] = r_stable & ~r_stable_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc     <= '0;
            r_sec_tick  <= 1'b0;
            r_hour      <= '0;
            r_min       <= '0;
            r_sec       <= '0;
            r_count     <= '0;
            r_inc_pulse <= 1'b0;
        end else begin
            r_sec_tick <= 1'b0;
            if (r_presc == c_PRESC_LAST) begin
                r_presc    <= '0;
                r_sec_tick <= 1'b1;
                // Full carry chain resolves in one edge so no illegal value is ever visible.
                if (r_sec == 6'd59) begin
                    r_sec <= '0;
                    if (r_min == 6'd59) begin
                        r_min  <= '0;
                        r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                    end else begin
                        r_min <= r_min + 6'd1;
                    end
                end else begin
                    r_sec <= r_sec + 6'd1;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            r_inc_pulse <= w_press[0];
            if (w_press[1]) begin
                r_count <= '0;
            end else if (w_press[0]) begin
                r_count <= (r_count == c_CNT_MAX) ? 8'd0 : r_count + 8'd1;
            end
        end
    end

    assign hour      = r_hour;
    assign min       = r_min;
    assign sec       = r_sec;
    assign count     = r_count;
    assign sec_tick  = r_sec_tick;
    assign inc_pulse = r_inc_pulse;

endmodule

`default_nettype wire

// File: tb/tb_clock_counter_core.sv
// ============================================================================
// tb_clock_counter_core: scoreboard bench, CLK_FREQ=10, DEBOUNCE_CYCLES=4
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clock_counter_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_inc;
    logic       btn_clr;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [7:0] count;
    logic       sec_tick;
    logic       inc_pulse;

    clock_counter_core #(
        .CLK_FREQ       (10),
        .DEBOUNCE_CYCLES(4),
        .COUNT_MAX      (99),
        .BTN_ACTIVE_LOW (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_inc  (btn_inc),
        .btn_clr  (btn_clr),
        .hour     (hour),
        .min      (min),
        .sec      (sec),
        .count    (count),
        .sec_tick (sec_tick),
        .inc_pulse(inc_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } tick_t;

    typedef struct {
        int         cyc;
        logic [7:0] c;
    } press_t;

    tick_t  tq[$];
    press_t iq[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Time-of-day reference: advances once per ten cycles out of reset.
    int         pm = 0;
    logic [4:0] mh = '0;
    logic [5:0] mm = '0;
    logic [5:0] ms = '0;
    bit         preload      = 1'b0;
    bit         preload_done = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (preload && !preload_done) begin
            mh = 5'd23; mm = 6'd59; ms = 6'd58;
            preload_done = 1'b1;
        end
        if (rst) begin
            pm = 0; mh = '0; mm = '0; ms = '0;
        end else if (pm == 9) begin
            pm = 0;
            if (ms == 6'd59) begin
                ms = '0;
                if (mm == 6'd59) begin
                    mm = '0;
                    mh = (mh == 5'd23) ? 5'd0 : mh + 5'd1;
                end else begin
                    mm = mm + 6'd1;
                end
            end else begin
                ms = ms + 6'd1;
            end
            tq.push_back('{cyc, mh, mm, ms});
        end else begin
            pm = pm + 1;
        end
    end

    // Monitor: pops an expectation whenever the DUT presents a pulse.
    always @(negedge clk) begin
        tick_t  t;
        press_t p;
        if (sec_tick) begin
            if (tq.size() == 0) begin
                chk("tick_unexpected", 1, 0);
            end else begin
                t = tq.pop_front();
                chk("tick_cycle", cyc, t.cyc);
                chk("tick_hms", {hour, min, sec}, {t.h, t.m, t.s});
            end
        end
        if (tq.size() > 0 && tq[0].cyc < cyc) begin
            t = tq.pop_front();
            chk("tick_missing_at", cyc, t.cyc);
        end
        if (inc_pulse) begin
            if (iq.size() == 0) begin
                chk("inc_unexpected", 1, 0);
            end else begin
                p = iq.pop_front();
                chk("inc_cycle", cyc, p.cyc);
                chk("inc_count", count, p.c);
            end
        end
        if (iq.size() > 0 && iq[0].cyc < cyc) begin
            p = iq.pop_front();
            chk("inc_missing_at", cyc, p.cyc);
        end
    end

    // Raw level first sampled at edge cyc+1; pulse expected after edge cyc+1+4+2.
    task automatic press(input bit inc, input bit clr, input int hold, input logic [7:0] exp_c);
        @(negedge clk);
        btn_inc = inc;
        btn_clr = clr;
        if (inc) iq.push_back('{cyc + 7, exp_c});
        repeat (hold) @(negedge clk);
        btn_inc = 1'b0;
        btn_clr = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        @(negedge clk);
        while (!sec_tick && n < 25) begin
            @(negedge clk);
            n++;
        end
        if (!sec_tick) chk(name, 0, 1);
    endtask

    initial begin
        int r0;
        rst     = 1'b1;
        btn_inc = 1'b0;
        btn_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_time", {hour, min, sec}, 0);
        chk("rst_count", count, 0);
        chk("rst_pulses", {sec_tick, inc_pulse}, 0);
        rst = 1'b0;
        r0  = cyc;

        wait_tick("first_tick_timeout");
        chk("first_tick_delay", cyc - r0, 10);
        chk("first_tick_sec", sec, 1);
        wait_tick("second_tick_timeout");
        chk("second_tick_delay", cyc - r0, 20);
        chk("second_tick_sec", sec, 2);

        @(negedge clk);
        force dut.r_hour = 5'd23;
        force dut.r_min  = 6'd59;
        force dut.r_sec  = 6'd58;
        preload = 1'b1;
        #1;
        release dut.r_hour;
        release dut.r_min;
        release dut.r_sec;
        wait_tick("pre_wrap_timeout");
        chk("pre_wrap_hms", {hour, min, sec}, {5'd23, 6'd59, 6'd59});
        wait_tick("wrap_timeout");
        chk("wrap_hms", {hour, min, sec}, 0);

        press(1'b1, 1'b0, 40, 8'd1);
        chk("held_press_count", count, 1);

        @(negedge clk); btn_inc = 1'b1;
        repeat (3) @(negedge clk); btn_inc = 1'b0;
        repeat (5) @(negedge clk); btn_inc = 1'b1;
        repeat (2) @(negedge clk); btn_inc = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_count", count, 1);

        press(1'b0, 1'b1, 8, 8'd0);
        chk("clear_count", count, 0);

        for (int k = 1; k <= 100; k++) begin
            press(1'b1, 1'b0, 8, (k == 100) ? 8'd0 : 8'(k));
            if (k == 99) chk("count_at_99", count, 99);
        end
        chk("count_wrapped", count, 0);

        for (int k = 1; k <= 57; k++) press(1'b1, 1'b0, 8, 8'(k));
        chk("count_57", count, 57);
        press(1'b1, 1'b1, 8, 8'd0);
        chk("clr_wins_count", count, 0);
        press(1'b1, 1'b0, 8, 8'd1);

        @(negedge clk); btn_inc = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1; btn_inc = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_time", {hour, min, sec}, 0);
        chk("midrst_count", count, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_count", count, 0);

        repeat (2) @(negedge clk);
        chk("inc_queue_drained", iq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
